io_pwm_periph: RTL and testbench
================================

# io_pwm_periph

Memory-mapped GPIO and multi-channel PWM peripheral on the core's data-memory port. It decodes a register window at the top of the address space and passes all other reads through from data memory. It drives a general-purpose output register and synchronises general-purpose inputs, adding sticky rising-edge flags with an interrupt. It also generates `NUM_PWM` hardware PWM waveforms from a shared prescaler and period counter.

## Interface
- `IO_W`, 32: GPIO width (1..32).
- `NUM_PWM`, 4: PWM channel count (1..8).
- `CNT_W`, 16: PWM period counter, period and duty register width (≤32).
- `BASE_ADDR`, 32'hFFFF_FF00: window base; window spans `BASE_ADDR`..`BASE_ADDR+0x3F`.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: **synchronous, active-low** reset (asserted when 0, sampled on `clk` rising edge).
- `write_mem` in 1: store strobe.
- `read_mem` in 1: load strobe.
- `data_address` in 32: byte address.
- `data_to_write` in 32: store data.
- `data_from_mem` in 32: data-memory read data (passthrough).
- `data_read` out 32: load result to core.
- `IO_in` in IO_W: asynchronous external inputs.
- `IO_out` out IO_W: GPIO output register.
- `pwm_out` out NUM_PWM: PWM waveforms.
- `edge_irq` out 1: OR of enabled edge flags.

## Operation
- Register map (offsets; `data_address[1:0]` must be 0, else unmapped). Unused high bits read 0, writes ignored.
  - 0x00 GPIO_OUT: RW.
  - 0x04 GPIO_IN: RO, synchronised value.
  - 0x08 EDGE_FLAG: RW1C.
  - 0x0C IRQ_EN: RW, per-bit.
  - 0x10 PWM_CTRL: bit0 `en`; bits[15:8] `presc`.
  - 0x14 PWM_PERIOD.
  - 0x20+4·i PWM_DUTY[i] for i < NUM_PWM.
- Unmapped offset inside the window: write ignored; read returns 0.
- Read path (combinational):
  - `read_mem` with an address in the window returns the register value.
  - Every other case, including no strobe, returns `data_from_mem`. No latch.
- Write path: `write_mem` to a mapped RW register updates it at the next edge. `write_mem` and `read_mem` together: the read returns the pre-write value.
- GPIO input:
  - Two-flop synchroniser, plus a previous-value flop.
  - `rise = sync & ~prev`.
  - `EDGE_FLAG <= (EDGE_FLAG & ~clear_mask) | rise`. Set wins over a simultaneous clear.
- `edge_irq = |(EDGE_FLAG & IRQ_EN)`.
- PWM:
  - Prescaler counts 0..`presc`; `tick` fires when it equals `presc`. `presc`=0 gives a tick every cycle.
  - Period counter `cnt` advances on `tick` and wraps from PERIOD to 0. The waveform period is (PERIOD+1)·(presc+1) cycles.
  - Each channel holds a shadow duty register. A write updates the shadow only; active duty loads from the shadow at wrap (tick with `cnt`==PERIOD), or immediately while `en`=0. Glitch-free.
  - `pwm_out[i] = en & (cnt < active_duty[i])`. Duty 0 gives constant low; duty > PERIOD gives constant high.
  - Writing PWM_PERIOD, or clearing `en`, zeroes the prescaler and `cnt` at the next edge.

## Timing
- Reset values: `IO_out`=0, `pwm_out`=0, `edge_irq`=0.
  - All registers, synchronisers, counters and duties are 0.
  - `data_read` follows `data_from_mem` (combinational, unaffected).
- Register write to output visibility: 1 cycle (`IO_out` changes at the edge that samples `write_mem`).
- Input latency:
  - `IO_in` rising before edge k gives GPIO_IN high after edge k+1.
  - EDGE_FLAG sets after edge k+2.
  - `edge_irq` rises in the same cycle as the flag.
- Reset asserted mid-period clears counters and forces `pwm_out` low at that edge. Flags pending at reset are lost.
- PERIOD=0 with `en`=1: `cnt` stays 0; output high iff duty ≥1.

## Structure
- Package `io_pwm_pkg`: register offset localparams, PWM_CTRL field positions, `EN_BIT`, `PRESC_LSB/MSB`.
- Sub-module `pwm_channel`: shadow/active duty registers, load-on-wrap logic, compare output. Instantiate `NUM_PWM` times with a generate loop.
- Top level: decode, GPIO/edge logic, prescaler and period counter.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `IO_in`=all-ones → all outputs 0. Release reset, wait 3 cycles → EDGE_FLAG reads 0xFFFFFFFF.
- GPIO: write 0xA5A5_0F0F to 0x00 → `IO_out`=0xA5A5_0F0F next cycle. Read 0x00 → same. Read non-window address 0x0000_1000 with `data_from_mem`=0x1234 → 0x1234.
- Edge/IRQ: IRQ_EN=0x1; pulse `IO_in[0]` → `edge_irq` high 3 edges later. Write 0x1 to 0x08 → flag and `edge_irq` clear. Clear coinciding with a new rise → flag stays 1.
- PWM basic: PERIOD=9, presc=0, DUTY0=3, en=1 → `pwm_out[0]` high 3 of every 10 cycles. Duty 0 → constant low. Duty 10 → constant high.
- Shadow update: change DUTY0 from 3 to 7 mid-period → the current period stays 3-high; the new value applies from the next `cnt`=0.
- Prescaler: presc=1, PERIOD=3, DUTY=2 → period 8 cycles, high 4. Unmapped offset 0x3C reads 0; unaligned address 0x...01 reads 0.

Source files
------------

// File: rtl/io_pwm_pkg.sv
// Register map and PWM_CTRL field layout shared by the GPIO/PWM peripheral
// and its PWM channel sub-module.
package io_pwm_pkg;

  localparam logic [5:0] OFF_GPIO_OUT   = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN    = 6'h04;
  localparam logic [5:0] OFF_EDGE_FLAG  = 6'h08;
  localparam logic [5:0] OFF_IRQ_EN     = 6'h0C;
  localparam logic [5:0] OFF_PWM_CTRL   = 6'h10;
  localparam logic [5:0] OFF_PWM_PERIOD = 6'h14;
  localparam logic [5:0] OFF_PWM_DUTY0  = 6'h20;

  localparam int EN_BIT    = 0;
  localparam int PRESC_LSB = 8;
  localparam int PRESC_MSB = 15;
  localparam int PRESC_W   = PRESC_MSB - PRESC_LSB + 1;

  function automatic logic [5:0] duty_offset(input int idx);
    return OFF_PWM_DUTY0 + 6'(4 * idx);
  endfunction

endpackage

// File: rtl/io_pwm_periph_pwm_channel.sv
// One PWM channel: shadow duty written by software, active duty reloaded only
// at period wrap (or freely while disabled) so a waveform never glitches.
module pwm_channel
  import io_pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             duty_we,
  input  logic [CNT_W-1:0] duty_wdata,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] shadow_duty,
  output logic             pwm
);

  logic [CNT_W-1:0] active_duty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow_duty <= '0;
      active_duty <= '0;
    end else begin
      if (duty_we) shadow_duty <= duty_wdata;
      if (load)    active_duty <= shadow_duty;
    end
  end

  assign pwm = en & (cnt < active_duty);

endmodule

// File: rtl/io_pwm_periph.sv
// Memory-mapped GPIO with synchronised inputs, sticky rising-edge flags and
// interrupt, plus NUM_PWM PWM outputs sharing one prescaler and period counter.
module io_pwm_periph
  import io_pwm_pkg::*;
#(
  parameter int          IO_W      = 32,
  parameter int          NUM_PWM   = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_mem,
  input  logic               read_mem,
  input  logic [31:0]        data_address,
  input  logic [31:0]        data_to_write,
  input  logic [31:0]        data_from_mem,
  output logic [31:0]        data_read,
  input  logic [IO_W-1:0]    IO_in,
  output logic [IO_W-1:0]    IO_out,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               edge_irq
);

  logic               in_window;
  logic [5:0]         offset;
  logic               wr_en;
  logic               wr_gpio, wr_flag, wr_irq, wr_ctrl, wr_period;
  logic [NUM_PWM-1:0] duty_we;

  logic [IO_W-1:0]    gpio_out;
  logic [IO_W-1:0]    io_sync_p0, io_sync_p1, io_prev_p2;
  logic [IO_W-1:0]    edge_flag, irq_en, rise, clr_mask;

  logic               pwm_en;
  logic [PRESC_W-1:0] presc, presc_cnt;
  logic [CNT_W-1:0]   period, cnt;
  logic               tick, wrap, restart, load;
  logic [CNT_W-1:0]   shadow_duty [NUM_PWM];
  logic [31:0]        reg_rdata;

  // Address decode: offsets are compared on all six bits, so any address with
  // nonzero [1:0] misses every register and reads back as zero.
  assign in_window = (data_address[31:6] == BASE_ADDR[31:6]);
  assign offset    = data_address[5:0];
  assign wr_en     = write_mem & in_window;
  assign wr_gpio   = wr_en & (offset == OFF_GPIO_OUT);
  assign wr_flag   = wr_en & (offset == OFF_EDGE_FLAG);
  assign wr_irq    = wr_en & (offset == OFF_IRQ_EN);
  assign wr_ctrl   = wr_en & (offset == OFF_PWM_CTRL);
  assign wr_period = wr_en & (offset == OFF_PWM_PERIOD);

  always_comb begin
    reg_rdata = '0;
    case (offset)
      OFF_GPIO_OUT:   reg_rdata = 32'(gpio_out);
      OFF_GPIO_IN:    reg_rdata = 32'(io_sync_p1);
      OFF_EDGE_FLAG:  reg_rdata = 32'(edge_flag);
      OFF_IRQ_EN:     reg_rdata = 32'(irq_en);
      OFF_PWM_CTRL:   reg_rdata = {16'h0, presc, 7'h0, pwm_en};
      OFF_PWM_PERIOD: reg_rdata = 32'(period);
      default:        reg_rdata = '0;
    endcase
    for (int i = 0; i < NUM_PWM; i++) begin
      if (offset == duty_offset(i)) reg_rdata = 32'(shadow_duty[i]);
    end
  end

  assign data_read = (read_mem & in_window) ? reg_rdata : data_from_mem;

  // GPIO input: p0/p1 synchronise, p2 holds the previous synchronised value.
  assign rise     = io_sync_p1 & ~io_prev_p2;
  assign clr_mask = wr_flag ? data_to_write[IO_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_out   <= '0;
      io_sync_p0 <= '0;
      io_sync_p1 <= '0;
      io_prev_p2 <= '0;
      edge_flag  <= '0;
      irq_en     <= '0;
      pwm_en     <= 1'b0;
      presc      <= '0;
      period     <= '0;
    end else begin
      io_sync_p0 <= IO_in;
      io_sync_p1 <= io_sync_p0;
      io_prev_p2 <= io_sync_p1;
      edge_flag  <= (edge_flag & ~clr_mask) | rise;
      if (wr_gpio)   gpio_out <= data_to_write[IO_W-1:0];
      if (wr_irq)    irq_en   <= data_to_write[IO_W-1:0];
      if (wr_ctrl) begin
        pwm_en <= data_to_write[EN_BIT];
        presc  <= data_to_write[PRESC_MSB:PRESC_LSB];
      end
      if (wr_period) period <= data_to_write[CNT_W-1:0];
    end
  end

  assign IO_out   = gpio_out;
  assign edge_irq = |(edge_flag & irq_en);

  // Shared timebase; >= comparisons recover if presc is lowered mid-count.
  assign tick    = (presc_cnt >= presc);
  assign wrap    = tick & (cnt >= period);
  assign restart = wr_period | ~pwm_en | (wr_ctrl & ~data_to_write[EN_BIT]);
  assign load    = wrap | ~pwm_en;

  always_ff @(posedge clk) begin
    if (!rst || restart) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else if (tick) begin
      presc_cnt <= '0;
      cnt       <= (cnt >= period) ? '0 : cnt + CNT_W'(1);
    end else begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_PWM; g++) begin : g_pwm
    assign duty_we[g] = wr_en & (offset == duty_offset(g));

    pwm_channel #(.CNT_W(CNT_W)) u_chan (
      .clk         (clk),
      .rst         (rst),
      .duty_we     (duty_we[g]),
      .duty_wdata  (data_to_write[CNT_W-1:0]),
      .load        (load),
      .en          (pwm_en),
      .cnt         (cnt),
      .shadow_duty (shadow_duty[g]),
      .pwm         (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_io_pwm_periph.sv
// Bench for io_pwm_periph: register vector table, edge/IRQ sequences and
// PWM waveform checks against analytically derived patterns.
module tb_io_pwm_periph;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write_mem = 1'b0, read_mem = 1'b0;
  logic [31:0] data_address = '0, data_to_write = '0, data_from_mem = '0;
  logic [31:0] data_read;
  logic [31:0] IO_in = '0;
  logic [31:0] IO_out;
  logic [3:0]  pwm_out;
  logic        edge_irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  io_pwm_periph #(
    .IO_W(32), .NUM_PWM(4), .CNT_W(16), .BASE_ADDR(32'hFFFF_FF00)
  ) dut (
    .clk(clk), .rst(rst), .write_mem(write_mem), .read_mem(read_mem),
    .data_address(data_address), .data_to_write(data_to_write),
    .data_from_mem(data_from_mem), .data_read(data_read),
    .IO_in(IO_in), .IO_out(IO_out), .pwm_out(pwm_out), .edge_irq(edge_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        chk;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected value travels through the scoreboard queue.
  task automatic sb_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", name, act);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    write_mem     = 1'b1;
    data_address  = addr;
    data_to_write = data;
    step();
    write_mem     = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr,
                          input logic [31:0] mem, input logic [31:0] exp);
    read_mem      = 1'b1;
    data_address  = addr;
    data_from_mem = mem;
    exp_q.push_back(exp);
    #1;
    sb_check(name, data_read);
    read_mem      = 1'b0;
  endtask

  task automatic pwm_check(input string name, input logic exp);
    exp_q.push_back({31'b0, exp});
    sb_check(name, {31'b0, pwm_out[0]});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FF00, 32'hA5A5_0F0F, 32'h0,         32'h0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h0,         32'h0,         32'hA5A5_0F0F};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0,         32'h0000_1234, 32'h0000_1234};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h0000_1111, 32'h0,         32'hA5A5_0F0F};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF00, 32'h0,         32'h0,         32'h0000_1111};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF04, 32'h0,         32'h0,         32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF3C, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF01, 32'h0,         32'hDEAD_BEEF, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FF00, 32'h0,         32'h0000_0055, 32'h0000_0055};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FF0C, 32'h0000_0001, 32'h0,         32'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF0C, 32'h0,         32'h0,         32'h0000_0001};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FF14, 32'hFFFF_1234, 32'h0,         32'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF14, 32'h0,         32'h0,         32'h0000_1234};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FF10, 32'hFFFF_AB00, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF10, 32'h0,         32'h0,         32'h0000_AB00};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FF24, 32'hFFFF_0055, 32'h0,         32'h0};
    vecs[16] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF24, 32'h0,         32'h0,         32'h0000_0055};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 32'hFFFF_FF30, 32'h0,         32'hDEAD_BEEF, 32'h0};

    // Reset with all inputs high
    rst   = 1'b0;
    IO_in = '1;
    data_from_mem = 32'h0000_CAFE;
    step();
    step();
    check("rst_io_out", IO_out, 32'h0);
    check("rst_pwm_out", {28'b0, pwm_out}, 32'h0);
    check("rst_edge_irq", {31'b0, edge_irq}, 32'h0);
    check("rst_passthru", data_read, 32'h0000_CAFE);
    rst = 1'b1;
    step();
    step();
    step();
    rd_check("rst_edge_flag", 32'hFFFF_FF08, 32'h0, 32'hFFFF_FFFF);
    wr(32'hFFFF_FF08, 32'hFFFF_FFFF);
    rd_check("flag_cleared", 32'hFFFF_FF08, 32'h0, 32'h0);

    // Register vector table
    for (int i = 0; i < 18; i++) begin
      write_mem     = vecs[i].wr;
      read_mem      = vecs[i].rd;
      data_address  = vecs[i].addr;
      data_to_write = vecs[i].wdata;
      data_from_mem = vecs[i].mem;
      if (vecs[i].chk) exp_q.push_back(vecs[i].exp);
      #1;
      if (vecs[i].chk) sb_check($sformatf("vec%0d_read", i), data_read);
      step();
      write_mem = 1'b0;
      read_mem  = 1'b0;
      if (vecs[i].wr && vecs[i].addr == 32'hFFFF_FF00)
        check($sformatf("vec%0d_io_out", i), IO_out, vecs[i].wdata);
    end

    // Edge flag / interrupt: one-cycle pulse on IO_in[0]
    IO_in = '0;
    step(); step(); step();
    IO_in[0] = 1'b1;
    step();
    IO_in[0] = 1'b0;
    check("irq_k", {31'b0, edge_irq}, 32'h0);
    step();
    check("irq_k1", {31'b0, edge_irq}, 32'h0);
    step();
    check("irq_k2", {31'b0, edge_irq}, 32'h1);
    rd_check("flag_set", 32'hFFFF_FF08, 32'h0, 32'h1);
    wr(32'hFFFF_FF08, 32'h1);
    check("irq_cleared", {31'b0, edge_irq}, 32'h0);
    rd_check("flag_w1c", 32'hFFFF_FF08, 32'h0, 32'h0);
    step(); step(); step();

    // Clear at the same edge as a new rise: set wins
    IO_in[0] = 1'b1;
    step();
    IO_in[0] = 1'b0;
    step();
    wr(32'hFFFF_FF08, 32'h1);
    check("set_wins_irq", {31'b0, edge_irq}, 32'h1);
    rd_check("set_wins_flag", 32'hFFFF_FF08, 32'h0, 32'h1);

    // PWM basic with mid-period shadow update: period 10, duty 3 then 7
    wr(32'hFFFF_FF14, 32'd9);
    wr(32'hFFFF_FF20, 32'd3);
    wr(32'hFFFF_FF10, 32'h1);
    for (int j = 0; j < 30; j++) begin
      pwm_check($sformatf("pwm_basic_j%0d", j), (j % 10) < ((j < 20) ? 3 : 7));
      if (j == 15) begin
        write_mem     = 1'b1;
        data_address  = 32'hFFFF_FF20;
        data_to_write = 32'd7;
      end
      step();
      write_mem = 1'b0;
    end

    // Duty 0: constant low
    wr(32'hFFFF_FF10, 32'h0);
    check("pwm_disabled", {28'b0, pwm_out}, 32'h0);
    wr(32'hFFFF_FF20, 32'd0);
    wr(32'hFFFF_FF10, 32'h1);
    for (int j = 0; j < 10; j++) begin
      pwm_check($sformatf("pwm_duty0_j%0d", j), 1'b0);
      step();
    end

    // Duty above PERIOD: constant high
    wr(32'hFFFF_FF10, 32'h0);
    wr(32'hFFFF_FF20, 32'd10);
    wr(32'hFFFF_FF10, 32'h1);
    for (int j = 0; j < 10; j++) begin
      pwm_check($sformatf("pwm_duty10_j%0d", j), 1'b1);
      step();
    end

    // Prescaler 1, period 3, duty 2: 8-cycle period, 4 high
    wr(32'hFFFF_FF10, 32'h0);
    wr(32'hFFFF_FF14, 32'd3);
    wr(32'hFFFF_FF20, 32'd2);
    wr(32'hFFFF_FF10, 32'h0000_0101);
    for (int j = 0; j < 16; j++) begin
      pwm_check($sformatf("pwm_presc_j%0d", j), (j % 8) < 4);
      step();
    end

    // PERIOD 0, duty 1: constant high
    wr(32'hFFFF_FF10, 32'h0);
    wr(32'hFFFF_FF14, 32'd0);
    wr(32'hFFFF_FF20, 32'd1);
    wr(32'hFFFF_FF10, 32'h1);
    for (int j = 0; j < 5; j++) begin
      pwm_check($sformatf("pwm_per0_j%0d", j), 1'b1);
      step();
    end

    // Reset mid-period with a pending flag
    check("pre_rst_irq", {31'b0, edge_irq}, 32'h1);
    rst = 1'b0;
    step();
    check("mid_rst_pwm", {28'b0, pwm_out}, 32'h0);
    check("mid_rst_irq", {31'b0, edge_irq}, 32'h0);
    check("mid_rst_io_out", IO_out, 32'h0);
    rst = 1'b1;
    step();
    step();
    check("post_rst_pwm", {28'b0, pwm_out}, 32'h0);
    rd_check("post_rst_flag", 32'hFFFF_FF08, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
